// File: rtl/down_count_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : down_count_monitor_if
// Description : Observation port of the down-counter monitor: sampled counter
//               controls in, checked pulses / fault capture / FSM state out.
// Revision    : 1.0
// ============================================================================
interface down_count_monitor_if #(
    parameter int N      = 4,
    parameter int WRAP_W = 8
);
    logic [N-1:0]      count_in;
    logic              count_en;
    logic              up_rst;
    logic              clear;
    logic              tc_pulse;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err;
    logic [N-1:0]      err_val;
    logic [N-1:0]      err_exp;
    logic [1:0]        state;

    modport master (
        output count_in, count_en, up_rst, clear,
        input  tc_pulse, wrap_pulse, wrap_cnt, err, err_val, err_exp, state
    );

    modport slave (
        input  count_in, count_en, up_rst, clear,
        output tc_pulse, wrap_pulse, wrap_cnt, err, err_val, err_exp, state
    );
endinterface
`default_nettype wire

// File: rtl/down_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : down_count_monitor
// Description : Checks that an upstream down counter follows its own enable
//               and reset one cycle later; flags terminal count, wraps, and
//               latches the first sequence error.
// Revision    : 1.0
// ============================================================================
module down_count_monitor #(
    parameter int N      = 4,
    parameter int WRAP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    down_count_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    localparam logic [N-1:0]      c_all_ones = {N{1'b1}};
    localparam logic [N-1:0]      c_zero     = '0;
    localparam logic [N-1:0]      c_one      = N'(1);
    localparam logic [WRAP_W-1:0] c_wrap_max = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] c_wrap_one = WRAP_W'(1);

    state_e            state_q,      state_d;
    logic [N-1:0]      prev_count_q, prev_count_d;
    logic              prev_en_q,    prev_en_d;
    logic              prev_rst_q,   prev_rst_d;
    logic              tc_pulse_q,   tc_pulse_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q,   wrap_cnt_d;
    logic              err_q,        err_d;
    logic [N-1:0]      err_val_q,    err_val_d;
    logic [N-1:0]      err_exp_q,    err_exp_d;

    logic [N-1:0]      w_expected;
    logic              w_match;
    logic              w_tc_hit;
    logic              w_wrap_hit;

    // What the upstream counter must show now, given last cycle's controls.
    always_comb begin
        w_expected = prev_count_q;
        if (prev_rst_q) begin
            w_expected = c_all_ones;
        end else if (prev_en_q) begin
            w_expected = prev_count_q - c_one;
        end
        w_match    = (mon.count_in == w_expected);
        w_tc_hit   = (mon.count_in == c_zero) && (prev_count_q != c_zero);
        // A reload through up_rst also lands on all-ones but is not a wrap.
        w_wrap_hit = prev_en_q && !prev_rst_q && (prev_count_q == c_zero)
                     && (mon.count_in == c_all_ones);
    end

    always_comb begin
        state_d      = state_q;
        prev_count_d = mon.count_in;
        prev_en_d    = mon.count_en;
        prev_rst_d   = mon.up_rst;
        tc_pulse_d   = 1'b0;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        err_d        = err_q;
        err_val_d    = err_val_q;
        err_exp_d    = err_exp_q;

        if (mon.clear) begin
            state_d    = ST_ACQUIRE;
            wrap_cnt_d = '0;
            err_d      = 1'b0;
            err_val_d  = '0;
            err_exp_d  = '0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_match) begin
                        tc_pulse_d   = w_tc_hit;
                        wrap_pulse_d = w_wrap_hit;
                        if (w_wrap_hit && (wrap_cnt_q != c_wrap_max)) begin
                            wrap_cnt_d = wrap_cnt_q + c_wrap_one;
                        end
                    end else begin
                        state_d   = ST_FAULT;
                        err_d     = 1'b1;
                        err_val_d = mon.count_in;
                        err_exp_d = w_expected;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_ACQUIRE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACQUIRE;
            prev_count_q <= '0;
            prev_en_q    <= 1'b0;
            prev_rst_q   <= 1'b0;
            tc_pulse_q   <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            err_q        <= 1'b0;
            err_val_q    <= '0;
            err_exp_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_en_q    <= prev_en_d;
            prev_rst_q   <= prev_rst_d;
            tc_pulse_q   <= tc_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_q        <= err_d;
            err_val_q    <= err_val_d;
            err_exp_q    <= err_exp_d;
        end
    end

    assign mon.state      = state_q;
    assign mon.tc_pulse   = tc_pulse_q;
    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.wrap_cnt   = wrap_cnt_q;
    assign mon.err        = err_q;
    assign mon.err_val    = err_val_q;
    assign mon.err_exp    = err_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_down_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_count_monitor
// Description : Directed plus random bench for down_count_monitor, three
//               configurations (N=4/W=8, N=4/W=2, N=1/W=2) on one stimulus.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_down_count_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    down_count_monitor_if #(.N(4), .WRAP_W(8)) ifa ();
    down_count_monitor_if #(.N(4), .WRAP_W(2)) ifb ();
    down_count_monitor_if #(.N(1), .WRAP_W(2)) ifc ();

    down_count_monitor #(.N(4), .WRAP_W(8)) u_a (.clk(clk), .rst(rst), .mon(ifa.slave));
    down_count_monitor #(.N(4), .WRAP_W(2)) u_b (.clk(clk), .rst(rst), .mon(ifb.slave));
    down_count_monitor #(.N(1), .WRAP_W(2)) u_c (.clk(clk), .rst(rst), .mon(ifc.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per instance, state 0/1/2 = ACQUIRE/TRACK/FAULT.
    int m_st[3], m_prev[3], m_pen[3], m_prst[3];
    int m_err[3], m_val[3], m_exp[3], m_tc[3], m_wr[3], m_wcnt[3];
    int mask[3] = '{15, 15, 1};
    int wmax[3] = '{255, 3, 3};

    int cur;
    int tca, wra, wrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int i);
        return (m_wcnt[i] > wmax[i]) ? wmax[i] : m_wcnt[i];
    endfunction

    task automatic model(input int c, input int en, input int ur, input int clr, input int rs);
        for (int i = 0; i < 3; i++) begin
            int ci;
            int ev;
            ci = c & mask[i];
            m_tc[i] = 0;
            m_wr[i] = 0;
            if (rs != 0) begin
                m_st[i] = 0; m_err[i] = 0; m_val[i] = 0; m_exp[i] = 0; m_wcnt[i] = 0;
                m_prev[i] = 0; m_pen[i] = 0; m_prst[i] = 0;
            end else begin
                if (m_prst[i] != 0)     ev = mask[i];
                else if (m_pen[i] != 0) ev = (m_prev[i] - 1) & mask[i];
                else                    ev = m_prev[i];
                if (clr != 0) begin
                    m_st[i] = 0; m_err[i] = 0; m_val[i] = 0; m_exp[i] = 0; m_wcnt[i] = 0;
                end else if (m_st[i] == 0) begin
                    m_st[i] = 1;
                end else if (m_st[i] == 1) begin
                    if (ci == ev) begin
                        m_tc[i] = (ci == 0 && m_prev[i] != 0) ? 1 : 0;
                        m_wr[i] = (m_pen[i] != 0 && m_prst[i] == 0 && m_prev[i] == 0
                                   && ci == mask[i]) ? 1 : 0;
                        m_wcnt[i] += m_wr[i];
                    end else begin
                        m_st[i] = 2; m_err[i] = 1; m_val[i] = ci; m_exp[i] = ev;
                    end
                end
                m_prev[i] = ci;
                m_pen[i]  = (en != 0) ? 1 : 0;
                m_prst[i] = (ur != 0) ? 1 : 0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " a.state"},    32'(ifa.state),      m_st[0]);
        chk({ctx, " a.err"},      32'(ifa.err),        m_err[0]);
        chk({ctx, " a.err_val"},  32'(ifa.err_val),    m_val[0]);
        chk({ctx, " a.err_exp"},  32'(ifa.err_exp),    m_exp[0]);
        chk({ctx, " a.tc"},       32'(ifa.tc_pulse),   m_tc[0]);
        chk({ctx, " a.wrap"},     32'(ifa.wrap_pulse), m_wr[0]);
        chk({ctx, " a.wrap_cnt"}, 32'(ifa.wrap_cnt),   sat(0));
        chk({ctx, " b.state"},    32'(ifb.state),      m_st[1]);
        chk({ctx, " b.err"},      32'(ifb.err),        m_err[1]);
        chk({ctx, " b.wrap"},     32'(ifb.wrap_pulse), m_wr[1]);
        chk({ctx, " b.wrap_cnt"}, 32'(ifb.wrap_cnt),   sat(1));
        chk({ctx, " c.state"},    32'(ifc.state),      m_st[2]);
        chk({ctx, " c.err"},      32'(ifc.err),        m_err[2]);
        chk({ctx, " c.err_val"},  32'(ifc.err_val),    m_val[2]);
        chk({ctx, " c.err_exp"},  32'(ifc.err_exp),    m_exp[2]);
        chk({ctx, " c.tc"},       32'(ifc.tc_pulse),   m_tc[2]);
        chk({ctx, " c.wrap"},     32'(ifc.wrap_pulse), m_wr[2]);
        chk({ctx, " c.wrap_cnt"}, 32'(ifc.wrap_cnt),   sat(2));
    endtask

    // Drive one sample, let the edge take it, then compare one step later.
    task automatic step(input int c, input int en, input int ur, input int clr,
                        input int rs, input string ctx);
        rst          = (rs != 0);
        ifa.count_in = 4'(c);
        ifb.count_in = 4'(c);
        ifc.count_in = 1'(c & 1);
        ifa.count_en = (en != 0);  ifb.count_en = (en != 0);  ifc.count_en = (en != 0);
        ifa.up_rst   = (ur != 0);  ifb.up_rst   = (ur != 0);  ifc.up_rst   = (ur != 0);
        ifa.clear    = (clr != 0); ifb.clear    = (clr != 0); ifc.clear    = (clr != 0);
        @(posedge clk);
        #1;
        model(c, en, ur, clr, rs);
        check_all(ctx);
        tca += int'(ifa.tc_pulse);
        wra += int'(ifa.wrap_pulse);
        wrb += int'(ifb.wrap_pulse);
    endtask

    task automatic run_down(input int n, input string ctx);
        for (int k = 0; k < n; k++) begin
            step(cur, 1, 0, 0, 0, ctx);
            cur = (cur - 1) & 15;
        end
    endtask

    initial begin
        int base_wcnt;
        tca = 0; wra = 0; wrb = 0;

        // Reset state
        step(0, 0, 0, 0, 1, "rst");
        step(9, 1, 1, 1, 1, "rst");
        chk("rst.state",    32'(ifa.state),    0);
        chk("rst.wrap_cnt", 32'(ifa.wrap_cnt), 0);

        // Reload, then a full 15..0,15 cycle
        step(3, 0, 1, 0, 0, "r33");
        cur = 15; tca = 0; wra = 0;
        run_down(17, "r33");
        chk("r33.tc_count",   32'(tca),          1);
        chk("r33.wrap_count", 32'(wra),          1);
        chk("r33.wrap_cnt",   32'(ifa.wrap_cnt), 1);
        chk("r33.err",        32'(ifa.err),      0);

        // Hold at 7 with the enable low
        run_down(7, "r34");
        tca = 0; wra = 0;
        for (int k = 0; k < 5; k++) step(7, 0, 0, 0, 0, "r34");
        chk("r34.pulses", 32'(tca + wra),   0);
        chk("r34.state",  32'(ifa.state),   1);
        chk("r34.err",    32'(ifa.err),     0);

        // Skip from 9 to 7, then fault must suppress pulses
        step(7, 0, 1, 0, 0, "r35");
        cur = 15;
        run_down(6, "r35");
        step(9, 1, 0, 0, 0, "r35");
        step(7, 1, 0, 0, 0, "r35");
        chk("r35.err",     32'(ifa.err),     1);
        chk("r35.err_val", 32'(ifa.err_val), 7);
        chk("r35.err_exp", 32'(ifa.err_exp), 8);
        chk("r35.state",   32'(ifa.state),   2);
        tca = 0; wra = 0; cur = 6;
        run_down(9, "r35");
        chk("r35.fault_pulses", 32'(tca + wra), 0);
        chk("r35.err_hold",     32'(ifa.err_val), 7);

        // Clear overrides a same-cycle mismatch
        step(11, 1, 0, 1, 0, "r36");
        step(10, 1, 0, 0, 0, "r36");
        step(9, 1, 0, 0, 0, "r36");
        step(7, 1, 0, 1, 0, "r36");
        chk("r36.err",      32'(ifa.err),      0);
        chk("r36.state",    32'(ifa.state),    0);
        chk("r36.wrap_cnt", 32'(ifa.wrap_cnt), 0);
        step(7, 0, 0, 0, 0, "r36");
        chk("r36.track", 32'(ifa.state), 1);

        // Saturation of the narrow wrap counter
        cur = 7; wrb = 0;
        for (int k = 1; k <= 4; k++) begin
            run_down((k == 1) ? 9 : 16, "r37");
            chk("r37.b_wrap_pulse", 32'(ifb.wrap_pulse), 1);
            chk("r37.b_wrap_cnt",   32'(ifb.wrap_cnt),   (k > 3) ? 3 : k);
            chk("r37.a_wrap_cnt",   32'(ifa.wrap_cnt),   k);
        end
        chk("r37.b_wrap_count", 32'(wrb), 4);

        // up_rst reload from 5 is accepted without counting a wrap
        run_down(9, "r38");
        base_wcnt = m_wcnt[0];
        step(5, 1, 1, 0, 0, "r38");
        wra = 0;
        step(15, 1, 0, 0, 0, "r38");
        chk("r38.err",      32'(ifa.err),        0);
        chk("r38.wrap",     32'(wra),            0);
        chk("r38.wrap_cnt", 32'(ifa.wrap_cnt),   4);
        chk("r38.b_cnt",    32'(ifb.wrap_cnt),   3);
        chk("r38.model",    32'(base_wcnt),      4);

        // Reset mid-fault discards history; first check on the second sample
        step(3, 1, 0, 0, 0, "r32");
        chk("r32.fault", 32'(ifa.state), 2);
        step(0, 0, 0, 0, 1, "r32");
        chk("r32.rst_err", 32'(ifa.err), 0);
        step(2, 0, 0, 0, 0, "r32");
        chk("r32.acq", 32'(ifa.err), 0);
        step(5, 0, 0, 0, 0, "r32");
        chk("r32.err",     32'(ifa.err),     1);
        chk("r32.err_val", 32'(ifa.err_val), 5);
        chk("r32.err_exp", 32'(ifa.err_exp), 2);

        // Randomised traffic: mostly legal counting with glitches and controls
        step(0, 0, 0, 0, 1, "rand");
        for (int k = 0; k < 800; k++) begin
            int r, c, en, ur, clr, rs;
            r   = int'($urandom_range(0, 99));
            en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            ur  = (r < 4) ? 1 : 0;
            clr = (r >= 4 && r < 8) ? 1 : 0;
            rs  = (r >= 98) ? 1 : 0;
            if ($urandom_range(0, 24) == 0) begin
                c = int'($urandom_range(0, 15));
            end else if (m_prst[0] != 0) begin
                c = 15;
            end else if (m_pen[0] != 0) begin
                c = (m_prev[0] - 1) & 15;
            end else begin
                c = m_prev[0];
            end
            step(c, en, ur, clr, rs, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/down_count_monitor.md
DOWN_COUNT_MONITOR -- requirements
Module: down_count_monitor

Interface
REQ-001 Parameter N, default 4, width of the monitored count (N >= 1).
REQ-002 Parameter WRAP_W, default 8, width of the wrap-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 count_in  input  N  count value from the upstream down counter.
REQ-006 count_en  input  1  the enable driving the upstream counter in the same cycle.
REQ-007 up_rst  input  1  the reset driving the upstream counter in the same cycle.
REQ-008 clear  input  1  synchronous clear of fault and wrap count; resynchronises the monitor.
REQ-009 tc_pulse  output  1  one-cycle pulse on a checked transition into count 0.
REQ-010 wrap_pulse  output  1  one-cycle pulse on a checked decrement from 0 to all-ones.
REQ-011 wrap_cnt  output  WRAP_W  saturating number of wrap events.
REQ-012 err  output  1  sticky sequence-error flag.
REQ-013 err_val  output  N  count_in captured at the first error.
REQ-014 err_exp  output  N  expected value at the first error.
REQ-015 state  output  2  FSM state: 0 ACQUIRE, 1 TRACK, 2 FAULT.

Function
REQ-016 Block SHALL register prev_count, prev_en and prev_rst from count_in, count_en and up_rst every cycle, in all states.
REQ-017 Expected value SHALL be: all-ones if prev_rst; else prev_count-1 modulo 2^N if prev_en; else prev_count.
REQ-018 ACQUIRE SHALL perform no check and SHALL move to TRACK on the next edge.
REQ-019 In TRACK, count_in == expected SHALL be a pass; any other value SHALL be a mismatch.
REQ-020 On a mismatch in TRACK, the next state SHALL be FAULT, err SHALL become 1, err_val SHALL take count_in and err_exp SHALL take the expected value.
REQ-021 FAULT SHALL perform no checks, SHALL assert no pulses, and SHALL hold err, err_val, err_exp and wrap_cnt until clear or rst.
REQ-022 tc_pulse SHALL be 1 for exactly one cycle after a TRACK pass with count_in == 0 and prev_count != 0.
REQ-023 wrap_pulse SHALL be 1 for exactly one cycle after a TRACK pass with prev_en=1, prev_rst=0, prev_count == 0 and count_in == all-ones.
REQ-024 A reload to all-ones caused by prev_rst SHALL NOT assert wrap_pulse or change wrap_cnt.
REQ-025 wrap_cnt SHALL increment together with wrap_pulse and SHALL saturate at 2^WRAP_W-1.
REQ-026 All outputs SHALL be registered; a pulse or error SHALL appear in the cycle after the count_in sample that caused it.
REQ-027 clear=1 SHALL take the next state to ACQUIRE and zero err, err_val, err_exp, wrap_cnt and both pulses.
REQ-028 clear SHALL override a same-cycle mismatch, so no error is recorded.
REQ-029 With N=1, all-ones equals 1; REQ-022 and REQ-023 SHALL apply unchanged.

Reset
REQ-030 rst=1 SHALL override clear and all other inputs.
REQ-031 rst=1 SHALL set state=ACQUIRE, set every output to 0, and clear prev_count, prev_en and prev_rst.
REQ-032 rst asserted mid-FAULT or mid-TRACK SHALL discard all history; the first check SHALL occur two samples after rst releases.

Verification
REQ-033 N=4; up_rst for 1 cycle, then count_en=1 as count_in runs 15..0,15 -> one tc_pulse after the 0 sample, one wrap_pulse after the 15 sample, wrap_cnt=1, err=0.
REQ-034 count_en=0 for 5 cycles with count_in held at 7 -> err=0, no pulses, state=TRACK.
REQ-035 count_en=1 while count_in steps 9 to 7 -> err=1, err_val=7, err_exp=8, state=FAULT; subsequent 0 and wrap produce no pulses.
REQ-036 Inject the REQ-035 mismatch with clear=1 in the same cycle -> err=0, state=ACQUIRE then TRACK, wrap_cnt=0.
REQ-037 WRAP_W=2 with 4 legal wraps -> wrap_cnt=3 after both the third and the fourth wrap, and wrap_pulse on each of the four.
REQ-038 up_rst=1 at count 5 with count_en=1 -> next count_in 15 is accepted, err=0, no wrap_pulse, wrap_cnt unchanged.
